keypad4x4_emulator: RTL and testbench



---
 rtl/keypad4x4_emulator_if.sv | 21 ++
 rtl/keypad4x4_emulator.sv | 170 +++++++++++++++++
 tb/tb_keypad4x4_emulator.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad4x4_emulator_if.sv
// Key-queue handshake, scanner column drive and emulated row/status lines of the keypad emulator.
interface keypad4x4_emulator_if;
  logic [3:0] key_in;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] col;
  logic [3:0] row;
  logic       pressed;
  logic       busy;
  logic       key_sent;

  modport master (
    output key_in, key_valid, col,
    input  key_ready, row, pressed, busy, key_sent
  );

  modport slave (
    input  key_in, key_valid, col,
    output key_ready, row, pressed, busy, key_sent
  );
endinterface

// File: rtl/keypad4x4_emulator.sv
// 4x4 keypad far-end emulator: queued key codes are replayed as press/hold/gap on the row lines.
// Optional contact bounce before each hold: define KEYPAD_EMU_BOUNCE_EN.
module keypad4x4_emulator #(
  parameter int HOLD_TICKS = 5,
  parameter int GAP_TICKS  = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_BITS   = 8
) (
  input  logic                  wClk20ms,
  input  logic                  rst,
  keypad4x4_emulator_if.slave   bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BOUNCE_TICKS = 3;
  typedef enum logic [1:0] {IDLE, HOLD, GAP, BOUNCE} state_t;
`else
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
`endif

  logic [3:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_BITS-1:0] r_cnt;
  logic [CNT_BITS-1:0] w_cnt_nxt;
  logic [3:0]       r_key;
  logic [3:0]       w_key_nxt;
  logic             r_key_sent;
  logic             w_key_sent_nxt;
  logic             w_contact;
  logic [1:0]       w_col_idx;
  logic [1:0]       w_row_idx;
  logic [3:0]       w_row;

  assign w_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  // Full is judged on the registered count, so a same-edge pop never frees a slot for a push.
  assign w_push  = bus.key_valid && !w_full;

  always_ff @(posedge wClk20ms or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge wClk20ms) begin
    if (w_push) r_mem[r_wptr] <= bus.key_in;
  end

  always_ff @(posedge wClk20ms or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_key      <= '0;
      r_key_sent <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_key      <= w_key_nxt;
      r_key_sent <= w_key_sent_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_key_nxt      = r_key;
    w_key_sent_nxt = 1'b0;
    w_pop          = 1'b0;
    w_contact      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_key_nxt = r_mem[r_rptr];
`ifdef KEYPAD_EMU_BOUNCE_EN
          w_cnt_nxt   = CNT_BITS'(BOUNCE_TICKS - 1);
          w_state_nxt = BOUNCE;
`else
          w_cnt_nxt   = CNT_BITS'(HOLD_TICKS - 1);
          w_state_nxt = HOLD;
`endif
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      BOUNCE: begin
        // closed / open / closed as the counter runs 2, 1, 0
        w_contact = (r_cnt != CNT_BITS'(1));
        if (r_cnt == '0) begin
          w_cnt_nxt   = CNT_BITS'(HOLD_TICKS - 1);
          w_state_nxt = HOLD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
`endif
      HOLD: begin
        w_contact = 1'b1;
        if (r_cnt == '0) begin
          w_key_sent_nxt = 1'b1;
          w_cnt_nxt      = CNT_BITS'(GAP_TICKS - 1);
          w_state_nxt    = GAP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      GAP: begin
        if (r_cnt == '0) w_state_nxt = IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_col_idx = 2'd0;
    w_row_idx = 2'd0;
    case (r_key)
      4'h1: begin w_col_idx = 2'd0; w_row_idx = 2'd0; end
      4'h4: begin w_col_idx = 2'd0; w_row_idx = 2'd1; end
      4'h7: begin w_col_idx = 2'd0; w_row_idx = 2'd2; end
      4'hE: begin w_col_idx = 2'd0; w_row_idx = 2'd3; end
      4'h2: begin w_col_idx = 2'd1; w_row_idx = 2'd0; end
      4'h5: begin w_col_idx = 2'd1; w_row_idx = 2'd1; end
      4'h8: begin w_col_idx = 2'd1; w_row_idx = 2'd2; end
      4'h0: begin w_col_idx = 2'd1; w_row_idx = 2'd3; end
      4'h3: begin w_col_idx = 2'd2; w_row_idx = 2'd0; end
      4'h6: begin w_col_idx = 2'd2; w_row_idx = 2'd1; end
      4'h9: begin w_col_idx = 2'd2; w_row_idx = 2'd2; end
      4'hF: begin w_col_idx = 2'd2; w_row_idx = 2'd3; end
      4'hA: begin w_col_idx = 2'd3; w_row_idx = 2'd0; end
      4'hB: begin w_col_idx = 2'd3; w_row_idx = 2'd1; end
      4'hC: begin w_col_idx = 2'd3; w_row_idx = 2'd2; end
      default: begin w_col_idx = 2'd3; w_row_idx = 2'd3; end
    endcase
  end

  // Row follows col combinationally so the scanner sees the contact within its own strobe.
  always_comb begin
    w_row = 4'hF;
    if (w_contact && !bus.col[w_col_idx]) w_row[w_row_idx] = 1'b0;
  end

  assign bus.row       = w_row;
  assign bus.pressed   = w_contact;
  assign bus.busy      = (r_state != IDLE) || !w_empty;
  assign bus.key_ready = !w_full;
  assign bus.key_sent  = r_key_sent;

endmodule

// File: tb/tb_keypad4x4_emulator.sv
// Bench for keypad4x4_emulator: directed literal scenarios plus random traffic against a timeline model.
module tb_keypad4x4_emulator;
  localparam int HOLD  = 5;
  localparam int GAP   = 3;
  localparam int DEPTH = 4;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BNC = 3;
`else
  localparam int BNC = 0;
`endif
  localparam int ACT = BNC + HOLD + GAP;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  keypad4x4_emulator_if bus();

  keypad4x4_emulator #(
    .HOLD_TICKS(HOLD),
    .GAP_TICKS (GAP),
    .FIFO_DEPTH(DEPTH),
    .CNT_BITS  (8)
  ) dut (
    .wClk20ms(clk),
    .rst     (rst),
    .bus     (bus)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Physical keypad face: layout[row][col]
  logic [3:0] layout [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic void key_pos(input logic [3:0] k, output int c, output int r);
    c = 0;
    r = 0;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (layout[ri][ci] == k) begin c = ci; r = ri; end
  endfunction

  // Timeline model: each popped key occupies ACT ticks after its pop edge plus one idle tick.
  logic [3:0] mq [$];
  logic [3:0] m_key = 4'h0;
  int m_start = -1000000;
  int m_next  = 0;
  int m_edge  = 0;

  always @(posedge clk) begin
    int pre, k, c, r;
    bit v, cont;
    logic [3:0] kin, er;
    v   = bus.key_valid;
    kin = bus.key_in;
    if (!rst) begin
      mq.delete();
      m_start = -1000000;
      m_next  = 0;
    end else begin
      pre = mq.size();
      if (m_edge >= m_next && pre > 0) begin
        m_key   = mq.pop_front();
        m_start = m_edge;
        m_next  = m_edge + ACT + 1;
      end
      if (v && pre < DEPTH) mq.push_back(kin);
    end
    #1;
    k    = m_edge - m_start;
    cont = (k < BNC) ? (k != 1) : (k < BNC + HOLD);
    key_pos(m_key, c, r);
    er = 4'hF;
    if (cont && bus.col[c] == 1'b0) er[r] = 1'b0;
    check("row",       bus.row,       er);
    check("pressed",   bus.pressed,   cont);
    check("key_sent",  bus.key_sent,  (k == BNC + HOLD));
    check("busy",      bus.busy,      (k < ACT) || (mq.size() > 0));
    check("key_ready", bus.key_ready, (mq.size() < DEPTH));
    m_edge++;
  end

  task automatic push(input logic [3:0] k);
    bus.key_in    = k;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic wait_pressed(input string name);
    int t = 0;
    while (!bus.pressed && t < 40) begin @(negedge clk); t++; end
    check(name, bus.pressed, 1);
  endtask

  task automatic wait_sent(input string name);
    int t = 0;
    while (!bus.key_sent && t < 40) begin @(negedge clk); t++; end
    check(name, bus.key_sent, 1);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (bus.busy && t < 200) begin @(negedge clk); t++; end
    check(name, bus.busy, 0);
  endtask

  // Strobe one column at a time, like the scanner, and decode which key answers.
  task automatic scan_key(output logic [3:0] k);
    k = 4'hX;
    for (int c = 0; c < 4; c++) begin
      bus.col = ~(4'(1) << c);
      #1;
      for (int r = 0; r < 4; r++)
        if (bus.row[r] == 1'b0) k = layout[r][c];
    end
    bus.col = 4'hF;
  endtask

  logic [3:0] order [5] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'hB};

  initial begin
    logic [3:0] got;
    bus.key_in    = 4'h3;
    bus.key_valid = 1'b1;
    bus.col       = 4'hF;
    rst           = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_row",   bus.row,       4'hF);
    check("rst_ready", bus.key_ready, 1);
    check("rst_busy",  bus.busy,      0);
    bus.key_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // Key 5 on column 1 answers on row 1
    bus.col = 4'b1101;
    push(4'h5);
    check("k5_queued_row",  bus.row,  4'hF);
    check("k5_queued_busy", bus.busy, 1);
    for (int i = 0; i < BNC; i++) begin
      @(negedge clk);
      check("k5_bounce_row", bus.row, (i == 1) ? 4'hF : 4'b1101);
    end
    for (int i = 0; i < HOLD; i++) begin
      @(negedge clk);
      check("k5_hold_row", bus.row, 4'b1101);
      check("k5_hold_sent", bus.key_sent, 0);
      if (i == 2) begin
        bus.col = 4'b1110;
        #1;
        check("k5_wrong_col", bus.row, 4'hF);
        bus.col = 4'b1101;
      end
    end
    @(negedge clk);
    check("k5_sent_pulse", bus.key_sent, 1);
    check("k5_gap_row",    bus.row,      4'hF);
    for (int i = 0; i < GAP - 1; i++) begin
      @(negedge clk);
      check("k5_gap_row",  bus.row,      4'hF);
      check("k5_gap_sent", bus.key_sent, 0);
      check("k5_gap_busy", bus.busy,     1);
    end
    @(negedge clk);
    check("k5_idle_busy", bus.busy, 0);

    // Key D with every column driven low
    bus.col = 4'b0000;
    push(4'hD);
    wait_pressed("kD_press_timeout");
    check("kD_row", bus.row, 4'b0111);
    wait_idle("kD_idle_timeout");

    // Key 1: col 0 high -> open; col 0 low -> row 0
    bus.col = 4'b0111;
    push(4'h1);
    wait_pressed("k1_press_timeout");
    check("k1_col0_high", bus.row, 4'hF);
    bus.col = 4'b1110;
    #1;
    check("k1_col0_low", bus.row, 4'b1110);
    wait_idle("k1_idle_timeout");

    // Five back-to-back keys fill the queue; a sixth on the full edge is dropped
    bus.col = 4'hF;
    for (int i = 0; i < 5; i++) begin
      check("b2b_ready_before", bus.key_ready, 1);
      bus.key_in    = order[i];
      bus.key_valid = 1'b1;
      @(negedge clk);
    end
    check("b2b_full", bus.key_ready, 0);
    bus.key_in = 4'hC;
    @(negedge clk);
    check("b2b_still_full", bus.key_ready, 0);
    bus.key_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_pressed("b2b_press_timeout");
      scan_key(got);
      check("b2b_order", got, order[i]);
      wait_sent("b2b_sent_timeout");
      @(negedge clk);
    end
    wait_idle("b2b_idle_timeout");

    // Asynchronous reset in the middle of a press with keys still queued
    bus.col = 4'b0000;
    push(4'hE);
    push(4'h6);
    push(4'h7);
    wait_pressed("ar_press_timeout");
    check("ar_row_before", bus.row, 4'b0111);
    #3 rst = 1'b0;
    #1;
    check("ar_row",     bus.row,       4'hF);
    check("ar_pressed", bus.pressed,   0);
    check("ar_busy",    bus.busy,      0);
    check("ar_ready",   bus.key_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ar_queue_gone", bus.busy, 0);

    // Random traffic with occasional mid-cycle resets
    for (int i = 0; i < 2000; i++) begin
      bus.key_valid = ($urandom_range(0, 2) == 0);
      bus.key_in    = 4'($urandom);
      bus.col       = 4'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #3 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    bus.key_valid = 1'b0;
    wait_idle("final_idle_timeout");
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
